// File: rtl/multi_pkg.sv
// Shared definitions for the shift-add multiplier controller and its bench:
// FSM state encoding and the product-width helper.
package multi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int PW(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/multi_ctrl.sv
// Sequencing controller for the shift-add multiplier: steps the shifter through the
// multiplier bits, accumulates the partial products and hands the product off on a
// valid/ready handshake. Optional build macro: EARLY_TERM_EN (stop once the remaining
// multiplier bits are all zero).
import multi_pkg::*;

module multi_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_valid,
    output logic                    ready,
    output logic [WIDTH-1:0]        cnt,
    input  logic [PW(WIDTH)-1:0]    AS,
    input  logic [WIDTH-1:0]        BS,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic [PW(WIDTH)-1:0]    product,
    output logic                    busy
);

    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(WIDTH - 1);

    state_t                 state;
    state_t                 state_nx;
    logic [WIDTH-1:0]       cnt_nx;
    logic [PW(WIDTH)-1:0]   acc;
    logic [PW(WIDTH)-1:0]   acc_nx;
    logic                   last;

`ifdef EARLY_TERM_EN
    // BS is B already shifted by cnt, so BS>>1 holds exactly the multiplier bits not yet seen.
    assign last = (cnt == CNT_LAST) || ((BS >> 1) == '0);
`else
    logic unused_bs;
    assign unused_bs = ^BS[WIDTH-1:1];
    assign last      = (cnt == CNT_LAST);
`endif

    assign ready   = (state == ST_IDLE);
    assign busy    = (state != ST_IDLE);
    assign o_valid = (state == ST_DONE);
    assign product = acc;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        acc_nx   = acc;
        unique case (state)
            ST_IDLE: begin
                if (i_valid) begin
                    state_nx = ST_CALC;
                    cnt_nx   = '0;
                    acc_nx   = '0;
                end
            end
            ST_CALC: begin
                if (BS[0]) begin
                    acc_nx = acc + AS;
                end
                if (last) begin
                    state_nx = ST_DONE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_DONE: begin
                // acc stays put so the product is stable for as long as downstream stalls.
                if (o_ready) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            acc   <= acc_nx;
        end
    end

endmodule
